nibble_serial_subtractor: RTL

- Multi-cycle WIDTH-bit subtractor that computes diff = a - b - borrowIn one 4-bit slice per clock, LSB nibble first.
- Each slice is a 4-bit borrow-lookahead stage, the subtract counterpart of the team's 4-bit carry-lookahead adder.
- Start/busy/done handshake; sits beside the ALU adders as a low-area subtract path.
- Result is registered and held until the next operation.

---
 rtl/nibble_serial_subtractor_pkg.sv | 13 +
 rtl/borrow_lookahead_subtractor_4bit.sv | 40 ++++
 rtl/nibble_serial_subtractor.sv | 117 +++++++++++
 3 files changed

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types for the nibble-serial subtractor.
// FSM state encoding and slice width.
package nibble_serial_subtractor_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/borrow_lookahead_subtractor_4bit.sv
// 4-bit borrow-lookahead subtract slice: d = x - y - borrowIn.
// Ports: x, y, borrowIn in; d, borrowOut (borrow out of bit 3) out.
module borrow_lookahead_subtractor_4bit
  import nibble_serial_subtractor_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               borrowIn,
  output logic [SLICE_W-1:0] d,
  output logic               borrowOut
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   br;

  assign g = ~x & y;
  assign p = ~(x ^ y);

  // Every borrow is a flat sum of products of g, p and borrowIn.
  assign br[0] = borrowIn;
  assign br[1] = g[0]
               | (p[0] & borrowIn);
  assign br[2] = g[1]
               | (p[1] & g[0])
               | (p[1] & p[0] & borrowIn);
  assign br[3] = g[2]
               | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & borrowIn);
  assign br[4] = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & borrowIn);

  assign d         = x ^ y ^ br[SLICE_W-1:0];
  assign borrowOut = br[SLICE_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle a - b - borrowIn, one nibble per clock, LSB first.
// Ports: start/busy/done handshake, a/b/borrowIn in; diff + flags out.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOut,
  output logic             overflow,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = $clog2(NSLICE);
  localparam int MSB    = WIDTH - 1;

  state_t             state;
  state_t             state_nx;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               br_q;
  logic [IDX_W-1:0]   idx;
  logic [SLICE_W-1:0] x;
  logic [SLICE_W-1:0] y;
  logic [SLICE_W-1:0] d;
  logic               bo_s;
  logic [WIDTH-1:0]   diff_nx;
  logic               last;
  logic               accept;

  assign last   = (idx == IDX_W'(NSLICE - 1));
  assign accept = start & (state != RUN);

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // One shared slice, steered by idx.
  assign x = a_q[SLICE_W*idx +: SLICE_W];
  assign y = b_q[SLICE_W*idx +: SLICE_W];

  borrow_lookahead_subtractor_4bit u_slice (
    .x         (x),
    .y         (y),
    .borrowIn  (br_q),
    .d         (d),
    .borrowOut (bo_s)
  );

  // Flags on the final edge must see the nibble being written now.
  always_comb begin
    diff_nx = diff;
    diff_nx[SLICE_W*idx +: SLICE_W] = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      br_q      <= 1'b0;
      idx       <= '0;
      diff      <= '0;
      borrowOut <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (accept) begin
      a_q  <= a;
      b_q  <= b;
      br_q <= borrowIn;
      idx  <= '0;
    end else if (state == RUN) begin
      diff <= diff_nx;
      br_q <= bo_s;
      idx  <= last ? '0 : idx + 1'b1;
      if (last) begin
        borrowOut <= bo_s;
        overflow  <= (a_q[MSB] ^ b_q[MSB])
                   & (diff_nx[MSB] ^ a_q[MSB]);
        zero      <= ~|diff_nx;
      end
    end
  end

endmodule
